// File: rtl/q_req_sched_pkg.sv
// Shared types and width helpers for the round-robin Q engine scheduler.
package q_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } q_sched_state_t;

  function automatic int qw(input int data_width);
    return 2 * data_width + 3;
  endfunction

  function automatic int idw(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/q_req_sched_if.sv
// Requester, response and engine-side signals of the scheduler, bundled as one interface.
interface q_req_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) ();
  import q_sched_pkg::*;

  localparam int QW  = qw(DATA_WIDTH);
  localparam int IDW = idw(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_c;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_d;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [QW-1:0]                 rsp_q;
  logic                          rsp_err;
  logic                          eng_input_valid;
  logic [DATA_WIDTH-1:0]         eng_a;
  logic [DATA_WIDTH-1:0]         eng_b;
  logic [DATA_WIDTH-1:0]         eng_c;
  logic [DATA_WIDTH-1:0]         eng_d;
  logic                          eng_output_valid;
  logic                          eng_done;
  logic [QW-1:0]                 eng_q;
  logic                          busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, rsp_ready,
           eng_output_valid, eng_done, eng_q,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_err,
           eng_input_valid, eng_a, eng_b, eng_c, eng_d, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, rsp_ready,
           eng_output_valid, eng_done, eng_q,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_err,
           eng_input_valid, eng_a, eng_b, eng_c, eng_d, busy
  );

endinterface

// File: rtl/q_req_sched_rr_arb.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module q_rr_arb
  import q_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic found_s;
  logic hit_s;
  int   idx_s;

  // Search from last_grant+1 upward; the first hit wins and blocks later hits.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IDW{1'b0}};
    found_s   = 1'b0;
    hit_s     = 1'b0;
    idx_s     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s        = (int'(last_grant) + k) % NUM_REQ;
      hit_s        = !found_s && req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_idx    = hit_s ? IDW'(idx_s) : grant_idx;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/q_req_sched.sv
// Shares one Q engine among NUM_REQ requesters: round-robin accept, issue, wait, respond.
module q_req_sched
  import q_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst,
  q_req_sched_if.slave  bus
);

  localparam int QW  = qw(DATA_WIDTH);
  localparam int IDW = idw(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT) + 1;

  q_sched_state_t        state_r;
  logic [IDW-1:0]        last_grant_r;
  logic [CW-1:0]         cnt_r;
  logic                  got_ov_r;
  logic [NUM_REQ-1:0]    grant_s;
  logic [IDW-1:0]        win_idx_s;
  logic                  handshake_s;
  logic                  rsp_valid_r;
  logic [IDW-1:0]        rsp_id_r;
  logic [QW-1:0]         rsp_q_r;
  logic                  rsp_err_r;
  logic                  eng_iv_r;
  logic [DATA_WIDTH-1:0] eng_a_r;
  logic [DATA_WIDTH-1:0] eng_b_r;
  logic [DATA_WIDTH-1:0] eng_c_r;
  logic [DATA_WIDTH-1:0] eng_d_r;

  q_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (win_idx_s)
  );

  // Ready is offered only in IDLE and is forced low while reset is held.
  assign bus.req_ready = (state_r == IDLE && rst) ? grant_s : {NUM_REQ{1'b0}};
  assign handshake_s   = |(bus.req_valid & bus.req_ready);

  assign bus.rsp_valid       = rsp_valid_r;
  assign bus.rsp_id          = rsp_id_r;
  assign bus.rsp_q           = rsp_q_r;
  assign bus.rsp_err         = rsp_err_r;
  assign bus.eng_input_valid = eng_iv_r;
  assign bus.eng_a           = eng_a_r;
  assign bus.eng_b           = eng_b_r;
  assign bus.eng_c           = eng_c_r;
  assign bus.eng_d           = eng_d_r;
  assign bus.busy            = (state_r != IDLE);

  // Scheduler FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NUM_REQ - 1);
      cnt_r        <= {CW{1'b0}};
      got_ov_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {IDW{1'b0}};
      rsp_q_r      <= {QW{1'b0}};
      rsp_err_r    <= 1'b0;
      eng_iv_r     <= 1'b0;
      eng_a_r      <= {DATA_WIDTH{1'b0}};
      eng_b_r      <= {DATA_WIDTH{1'b0}};
      eng_c_r      <= {DATA_WIDTH{1'b0}};
      eng_d_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            eng_a_r      <= bus.req_a[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            eng_b_r      <= bus.req_b[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            eng_c_r      <= bus.req_c[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            eng_d_r      <= bus.req_d[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            rsp_id_r     <= win_idx_s;
            last_grant_r <= win_idx_s;
            eng_iv_r     <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          eng_iv_r <= 1'b0;
          cnt_r    <= {CW{1'b0}};
          got_ov_r <= 1'b0;
          state_r  <= WAIT;
        end
        WAIT: begin
          // A done without any output_valid still delivers the engine's Q.
          if (bus.eng_output_valid || (bus.eng_done && !got_ov_r)) begin
            rsp_q_r <= bus.eng_q;
          end
          if (bus.eng_output_valid) begin
            got_ov_r <= 1'b1;
          end
          if (bus.eng_done) begin
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            rsp_q_r     <= {QW{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_req_sched.sv
// Scoreboard bench for q_req_sched with a behavioural Q engine on the engine port.
module tb_q_req_sched;

  localparam int DW      = 16;
  localparam int NR      = 4;
  localparam int TO      = 64;
  localparam int QW      = 2 * DW + 3;
  localparam int ENG_LAT = 3;

  typedef struct {
    logic [1:0]           id;
    logic signed [QW-1:0] q;
    logic                 err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   acc_total = 0;
  int   eng_iv_cnt = 0;
  int   acc_ids[$];
  exp_t exp_q[$];
  int   eng_mode = 0;

  always #5 clk = ~clk;

  q_req_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  q_req_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic signed [QW-1:0] eng_calc(input logic signed [DW-1:0] a, b, c, d);
    longint t;
    t = ((longint'(a) - longint'(b)) * (64'sd1 + 64'sd3 * longint'(c)) - 64'sd4 * longint'(d)) >>> 1;
    return QW'(t);
  endfunction

  function automatic void push_exp(input int id, input longint q, input logic err);
    exp_t e;
    e.id  = 2'(id);
    e.q   = QW'(q);
    e.err = err;
    exp_q.push_back(e);
  endfunction

  // Behavioural engine: modes 0 ov+done together, 1 never done, 2 ov then late done, 3 done only.
  initial begin
    int e_cnt;
    int d_cnt;
    logic signed [QW-1:0] res;
    e_cnt = 0;
    d_cnt = 0;
    res = '0;
    bus.eng_output_valid = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_q = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_output_valid = 1'b0;
      bus.eng_done = 1'b0;
      if (rst !== 1'b1) begin
        e_cnt = 0;
        d_cnt = 0;
      end else if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          case (eng_mode)
            0: begin bus.eng_output_valid = 1'b1; bus.eng_done = 1'b1; bus.eng_q = res; end
            2: begin bus.eng_output_valid = 1'b1; bus.eng_q = res; d_cnt = 2; end
            3: begin bus.eng_done = 1'b1; bus.eng_q = res; end
            default: ;
          endcase
        end
      end else if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) begin
          bus.eng_done = 1'b1;
          bus.eng_q = 35'h2A5A5;
        end
      end else if (bus.eng_input_valid) begin
        e_cnt = ENG_LAT;
        res = eng_calc(bus.eng_a, bus.eng_b, bus.eng_c, bus.eng_d);
      end
    end
  end

  // Request-side monitor: records accepts and engine issues, checks ready is one-hot.
  initial begin
    logic [NR-1:0] hs;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        hs = bus.req_valid & bus.req_ready;
        if (hs != '0) begin
          checks++;
          if ($countones(hs) != 1) begin
            errors++;
            $display("FAIL ready_onehot got %b want one-hot", hs);
          end
          for (int i = 0; i < NR; i++) if (hs[i]) acc_ids.push_back(i);
          acc_total++;
        end
        if (bus.eng_input_valid) eng_iv_cnt++;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got id=%0d q=%0d err=%b want none", bus.rsp_id, $signed(bus.rsp_q), bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_id !== e.id || bus.rsp_q !== e.q || bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_data got id=%0d q=%0d err=%b want id=%0d q=%0d err=%b",
                     bus.rsp_id, $signed(bus.rsp_q), bus.rsp_err, e.id, e.q, e.err);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int c, input int d);
    bus.req_a[i*DW +: DW] = 16'(a);
    bus.req_b[i*DW +: DW] = 16'(b);
    bus.req_c[i*DW +: DW] = 16'(c);
    bus.req_d[i*DW +: DW] = 16'(d);
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int target, input logic [NR-1:0] clr, input string nm);
    int n = 0;
    while (acc_total < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (acc_total < target) begin
      errors++;
      $display("FAIL %s_accept got %0d accepts want %0d", nm, acc_total, target);
    end
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~clr;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending busy=%b want 0 pending idle", nm, exp_q.size(), bus.busy);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.req_d = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.eng_input_valid, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {bus.rsp_valid, bus.rsp_err, bus.eng_input_valid, bus.busy});
    end
    checks++;
    if (bus.rsp_q !== '0 || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_rsp got q=%0d id=%0d ready=%b want 0", bus.rsp_q, bus.rsp_id, bus.req_ready);
    end
    checks++;
    if ({bus.eng_a, bus.eng_b, bus.eng_c, bus.eng_d} !== 64'd0) begin
      errors++;
      $display("FAIL reset_eng got %h want 0", {bus.eng_a, bus.eng_b, bus.eng_c, bus.eng_d});
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_single();
    int acc0 = acc_total;
    int iv0 = eng_iv_cnt;
    eng_mode = 0;
    @(posedge clk);
    #2;
    set_req(2, 10, 5, 2, 3);
    push_exp(2, 11, 1'b0);
    wait_acc(acc0 + 1, 4'b0100, "single");
    wait_drain("single");
    checks++;
    if (acc_total - acc0 != 1 || acc_ids[acc0] != 2) begin
      errors++;
      $display("FAIL single_grant got %0d accepts last=%0d want 1 accept of 2", acc_total - acc0, acc_ids[acc_ids.size()-1]);
    end
    checks++;
    if (eng_iv_cnt - iv0 != 1) begin
      errors++;
      $display("FAIL single_issue got %0d pulses want 1", eng_iv_cnt - iv0);
    end
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    int acc0;
    do_reset();
    acc0 = acc_total;
    eng_mode = 0;
    @(posedge clk);
    #2;
    set_req(0, 1, 1, 1, 1);
    set_req(1, 20, 8, 1, 5);
    set_req(2, 3, 1, 0, 0);
    set_req(3, 0, 0, 0, -1);
    push_exp(0, -2, 1'b0);
    push_exp(1, 14, 1'b0);
    push_exp(2, 1, 1'b0);
    push_exp(3, 2, 1'b0);
    push_exp(0, -2, 1'b0);
    wait_acc(acc0 + 5, 4'b1111, "fair");
    wait_drain("fair");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (acc_ids.size() <= acc0 + k || acc_ids[acc0 + k] != order[k]) begin
        errors++;
        $display("FAIL fair_order_%0d got %0d want %0d", k,
                 (acc_ids.size() > acc0 + k) ? acc_ids[acc0 + k] : -1, order[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int acc0 = acc_total;
    int n = 0;
    eng_mode = 0;
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b0;
    set_req(1, 20, 8, 1, 5);
    set_req(3, 0, 0, 0, -1);
    push_exp(1, 14, 1'b0);
    push_exp(3, 2, 1'b0);
    wait_acc(acc0 + 1, 4'b0010, "bp");
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || $signed(bus.rsp_q) !== 35'sd14 ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0 || bus.eng_input_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b id=%0d q=%0d e=%b rdy=%b iv=%b want v=1 id=1 q=14 e=0 rdy=0000 iv=0",
                 k, bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_q), bus.rsp_err, bus.req_ready, bus.eng_input_valid);
      end
    end
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b1;
    wait_acc(acc0 + 2, 4'b1000, "bp2");
    wait_drain("bp");
  endtask

  task automatic test_extreme();
    int acc0 = acc_total;
    eng_mode = 2;
    @(posedge clk);
    #2;
    set_req(0, -32768, 0, 0, 0);
    push_exp(0, -16384, 1'b0);
    wait_acc(acc0 + 1, 4'b0001, "ext1");
    wait_drain("ext1");
    eng_mode = 3;
    @(posedge clk);
    #2;
    set_req(0, -5, 10, 3, -2);
    push_exp(0, -71, 1'b0);
    wait_acc(acc0 + 2, 4'b0001, "ext2");
    wait_drain("ext2");
  endtask

  task automatic test_timeout();
    int acc0 = acc_total;
    int n = 0;
    eng_mode = 1;
    @(posedge clk);
    #2;
    set_req(2, 10, 5, 2, 3);
    push_exp(2, 0, 1'b1);
    while (bus.eng_input_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid[2] = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles want %0d", n, TO + 1);
    end
    wait_drain("timeout");
    eng_mode = 0;
    @(posedge clk);
    #2;
    set_req(3, 0, 0, 0, -1);
    push_exp(3, 2, 1'b0);
    wait_acc(acc0 + 2, 4'b1000, "after_to");
    wait_drain("after_to");
  endtask

  task automatic test_reset_mid_wait();
    int acc0 = acc_total;
    eng_mode = 1;
    @(posedge clk);
    #2;
    set_req(2, 7, 1, 1, 1);
    wait_acc(acc0 + 1, 4'b0100, "rmw");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rmw_busy got %b want 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.eng_input_valid, bus.busy} !== 4'b0000 ||
        bus.rsp_q !== '0 || bus.rsp_id !== 2'd0 || bus.eng_a !== 16'd0) begin
      errors++;
      $display("FAIL rmw_outputs got v=%b e=%b iv=%b busy=%b q=%0d id=%0d a=%0d want all 0",
               bus.rsp_valid, bus.rsp_err, bus.eng_input_valid, bus.busy, bus.rsp_q, bus.rsp_id, bus.eng_a);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    eng_mode = 0;
    set_req(3, 0, 0, 0, -1);
    set_req(0, 1, 1, 1, 1);
    push_exp(0, -2, 1'b0);
    push_exp(3, 2, 1'b0);
    wait_acc(acc0 + 2, 4'b0001, "rmw0");
    checks++;
    if (acc_ids.size() < acc0 + 2 || acc_ids[acc0 + 1] != 0) begin
      errors++;
      $display("FAIL rmw_first got %0d want 0", (acc_ids.size() >= acc0 + 2) ? acc_ids[acc0 + 1] : -1);
    end
    wait_acc(acc0 + 3, 4'b1000, "rmw3");
    wait_drain("rmw");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_extreme();
    test_timeout();
    test_reset_mid_wait();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_req_sched.md
# q_req_sched

Round-robin scheduler that shares a single `Q_top` engine, which computes Q = ((a−b)·(1+3c) − 4d) >>> 1, among `NUM_REQ` independent requesters. It accepts one operand set at a time through per-requester valid/ready handshakes and sequences the engine's `input_valid`/`output_valid`/`done` protocol. It returns each result, tagged with the requester index, on a single back-pressured response port. It sits directly in front of `Q_top`; requesters never drive the engine themselves.

## Interface
- `DATA_WIDTH`, 16, operand width; result width QW = 2*DATA_WIDTH+3
- `NUM_REQ`, 4, number of requesters (≥2); IDW = $clog2(NUM_REQ)
- `TIMEOUT`, 64, max cycles in WAIT before aborting
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `req_a`, `req_b`, `req_c`, `req_d`  in  NUM_REQ*DATA_WIDTH each  packed signed operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  response consumer accept
- `rsp_id`  out  IDW  index of the requester owning the result
- `rsp_q`  out  QW  signed result
- `rsp_err`  out  1  engine timed out; `rsp_q` = 0
- `eng_input_valid`  out  1  to `Q_top.input_valid`
- `eng_a`, `eng_b`, `eng_c`, `eng_d`  out  DATA_WIDTH each  to `Q_top` operands
- `eng_output_valid`, `eng_done`  in  1 each  from `Q_top`
- `eng_q`  in  QW  from `Q_top.Q`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Winner is the first asserted `req_valid` searched from `last_grant+1` upward, wrapping modulo NUM_REQ.
  - `req_ready[winner]` is driven combinationally. The handshake completes on the edge where valid&&ready.
  - On handshake: latch that requester's operands into the `eng_*` registers, latch `rsp_id` = winner, set `last_grant` = winner, go to ISSUE.
- **ISSUE**: drive `eng_input_valid` = 1 for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT**
  - On any cycle with `eng_output_valid` = 1, capture `eng_q` into `rsp_q`.
  - On `eng_done` = 1, go to RESP. If `output_valid` and `done` arrive in the same cycle, capture and transition together.
  - If `done` arrives without a prior or simultaneous `output_valid`, capture `eng_q` on the `done` cycle.
  - If the counter reaches TIMEOUT−1 with no `done`, go to RESP with `rsp_err` = 1 and `rsp_q` = 0.
- **RESP**
  - Hold `rsp_valid`, `rsp_id`, `rsp_q` and `rsp_err` stable until `rsp_ready`.
  - On valid&&ready, go to IDLE and clear `rsp_err`.
- `req_ready` is all-zero outside IDLE. A requester must keep its valid and operands stable until accepted.
- No starvation: a continuously asserted request is granted within NUM_REQ accepts.
- Width rules:
  - Operands pass through unmodified, signed.
  - `rsp_q` is exactly QW bits. No truncation or extension beyond what the engine provides.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant` = NUM_REQ−1 (requester 0 has first priority), timeout counter 0.
- Reset mid-operation returns to IDLE immediately and drops `eng_input_valid`. An in-flight result is discarded and no response is issued.
- Handshake at edge T:
  - `eng_input_valid` is high during cycle T+1.
  - WAIT begins at T+2.
  - `rsp_valid` rises the cycle after `eng_done` is sampled.
- Minimum request-to-response latency = engine latency + 2 cycles.
- `rsp_ready` already high when RESP is entered: response is held one cycle, IDLE follows, and the next accept can occur one cycle later.
- Back-to-back throughput: one job per (engine latency + 3) cycles at best.
- `eng_output_valid`/`eng_done` seen in IDLE, ISSUE or RESP are ignored.

## Structure
- Package `q_sched_pkg`:
  - state enum `q_sched_state_t` {IDLE, ISSUE, WAIT, RESP}
  - width functions `qw(DATA_WIDTH)` and `idw(NUM_REQ)`
- Sub-module `q_rr_arb`: parameterized combinational round-robin priority picker. Inputs are the request vector and `last_grant`. Outputs are the one-hot grant and the encoded index.
- The top instantiates `q_rr_arb` and the FSM. `Q_top` is instantiated at the next level up, not inside this block.

## Test plan
- **Single request:** requester 2 sends a=10, b=5, c=2, d=3.
  - `req_ready[2]` pulses once and `eng_input_valid` pulses once.
  - Response: `rsp_id` = 2, `rsp_q` = 11, `rsp_err` = 0.
- **Fairness:** all four requesters assert continuously after reset.
  - Grants occur in order 0,1,2,3,0; each `rsp_id` matches.
  - Requester 1 with a=20, b=8, c=1, d=5 returns 14.
- **Back-pressure:** hold `rsp_ready` = 0 for 10 cycles in RESP.
  - `rsp_*` stays stable, `req_ready` stays 0, no second `eng_input_valid`.
- **Extreme operands:** a=0x8000, b=c=d=0 returns −16384. a=−5, b=10, c=3, d=−2 returns −71.
- **Timeout:** the engine model never asserts `done`. After TIMEOUT cycles, `rsp_err` = 1 and `rsp_q` = 0; the next request is served normally.
- **Reset mid-WAIT:** assert `rst` low during WAIT.
  - All outputs go to 0, no response is issued.
  - After release, requester 0 wins first.
